bist_scheduler: RTL and testbench
=================================

BIST_SCHEDULER -- requirements
Module: bist_scheduler

Interface
REQ-001 Parameter NREQ, default 4: number of BIST requesters (targets) sharing one BIST controller, 2..8.
REQ-002 Parameter NTIMEOUT, default 1023: maximum WAIT cycles before a session is aborted.
REQ-003 Parameter SIGW, default 16: signature width.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  NREQ  per-target BIST request, level, held until that target's done.
REQ-007 grant  output  NREQ  one-hot owner of the current session; all-zero when idle.
REQ-008 bist_start  output  1  one-cycle start pulse to the BIST controller.
REQ-009 bist_finish  input  1  one-cycle finish pulse from the BIST controller.
REQ-010 signature  input  SIGW  response signature, valid in the bist_finish cycle.
REQ-011 golden  input  SIGW  expected signature of the granted target, stable while grant is nonzero.
REQ-012 done  output  NREQ  one-cycle pulse on the bit of the target whose session ended.
REQ-013 pass  output  1  result, valid only while done is nonzero; 0 otherwise.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 timeout_err  output  1  sticky flag, set on any session timeout.

Function
REQ-016 The FSM SHALL have states IDLE, START, WAIT, CHECK; all outputs SHALL be registered or decoded from registered state only.
REQ-017 IDLE: if req is nonzero, the FSM SHALL select one target round-robin, starting the search at rr_ptr, register grant, and go to START on the same edge.
REQ-018 START: bist_start SHALL be 1 for exactly this cycle; the wait counter SHALL clear; next state WAIT.
REQ-019 WAIT: if bist_finish is 1, the FSM SHALL register pass_r = (signature == golden) and go to CHECK.
REQ-020 WAIT: else the counter SHALL increment; when the counter equals NTIMEOUT, the FSM SHALL register pass_r = 0, set timeout_err, and go to CHECK.
REQ-021 If bist_finish and the timeout condition coincide, bist_finish SHALL win (normal compare, timeout_err unchanged).
REQ-022 CHECK: done SHALL equal grant and pass SHALL equal pass_r for this single cycle; rr_ptr SHALL load (granted index + 1) mod NREQ; grant SHALL clear; next state IDLE.
REQ-023 Latency: req seen at edge n in IDLE -> bist_start high in cycle n+1; bist_finish at edge m -> done high in cycle m+1.
REQ-024 bist_finish outside WAIT SHALL be ignored.
REQ-025 Deassertion of the granted req during a session SHALL NOT abort it; the session completes and done still pulses.
REQ-026 New requests arriving while busy SHALL be held off, not lost, and arbitrated on return to IDLE.
REQ-027 A requester still asserting req after its done SHALL be re-arbitrated with lowest priority (round-robin fairness); no target SHALL wait more than NREQ-1 sessions.
REQ-028 The wait counter SHALL be $clog2(NTIMEOUT+1) bits and SHALL NOT wrap.

Reset
REQ-029 When reset is high, the FSM SHALL return asynchronously to IDLE, and grant, done, pass, bist_start, busy, timeout_err, pass_r, counter and rr_ptr SHALL all be 0.
REQ-030 Reset mid-session SHALL abort without a done pulse; timeout_err SHALL clear only by reset.

Verification
REQ-031 Single: req=0001, signature==golden=16'hA5A5, bist_finish 650 cycles after bist_start -> grant=0001, one bist_start pulse, done=0001 with pass=1, then busy=0.
REQ-032 Fail: same with signature=16'hA5A4 -> done=0001, pass=0, timeout_err=0.
REQ-033 Round-robin: req=1111 held continuously -> grants in order 0001, 0010, 0100, 1000, 0001, each with its done pulse.
REQ-034 Timeout: NTIMEOUT=10, no bist_finish -> done after 10 WAIT cycles, pass=0, timeout_err=1 and remains 1 until reset.
REQ-035 Reset during WAIT -> all outputs 0 immediately, no done; after release, req=0100 gives normal session.
REQ-036 Stray bist_finish in IDLE and coincident finish/timeout -> no effect in IDLE; coincident case gives compare result, timeout_err=0.

Source files
------------

// File: rtl/bist_scheduler.sv
// Round-robin scheduler that shares one BIST controller among NREQ targets.
// Runs one session at a time, compares the signature and flags timeouts.
module bist_scheduler #(
    parameter int NREQ     = 4,
    parameter int NTIMEOUT = 1023,
    parameter int SIGW     = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic            bist_start,
    input  logic            bist_finish,
    input  logic [SIGW-1:0] signature,
    input  logic [SIGW-1:0] golden,
    output logic [NREQ-1:0] done,
    output logic            pass,
    output logic            busy,
    output logic            timeout_err
);

    localparam int CW = $clog2(NTIMEOUT + 1);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        CHECK
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   gidx;
    logic            pass_r;

    logic [NREQ-1:0] pick;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   scan;
    logic            found;
    int              j;

    // Round-robin search: first requester at or after rr_ptr wins.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        scan     = '0;
        j        = 0;
        for (int i = 0; i < NREQ; i++) begin
            j    = (int'(rr_ptr) + i) % NREQ;
            scan = PW'(j);
            if (!found && req[scan]) begin
                found       = 1'b1;
                pick[scan]  = 1'b1;
                pick_idx    = scan;
            end
        end
    end

    // Session FSM with its grant, counter, result and pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            gidx        <= '0;
            cnt         <= '0;
            rr_ptr      <= '0;
            pass_r      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant <= pick;
                        gidx  <= pick_idx;
                        state <= START;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (bist_finish) begin
                        pass_r <= (signature == golden);
                        state  <= CHECK;
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(NTIMEOUT - 1)) begin
                            pass_r      <= 1'b0;
                            timeout_err <= 1'b1;
                            state       <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    rr_ptr <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
                    grant  <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bist_start = (state == START);
    assign busy       = (state != IDLE);
    assign done       = (state == CHECK) ? grant : '0;
    assign pass       = (state == CHECK) && pass_r;

endmodule

// File: tb/tb_bist_scheduler.sv
// Scoreboard bench for bist_scheduler: expected done/pass pushed per
// session, popped and compared whenever the DUT pulses done.
module tb_bist_scheduler;

    localparam int NREQ = 4;
    localparam int NT   = 1023;
    localparam int SIGW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic            bist_start;
    logic            bist_finish;
    logic [SIGW-1:0] signature;
    logic [SIGW-1:0] golden;
    logic [NREQ-1:0] done;
    logic            pass;
    logic            busy;
    logic            timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int last_wait;
    logic [4:0] sb[$];

    bist_scheduler #(
        .NREQ    (NREQ),
        .NTIMEOUT(NT),
        .SIGW    (SIGW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .grant      (grant),
        .bist_start (bist_start),
        .bist_finish(bist_finish),
        .signature  (signature),
        .golden     (golden),
        .done       (done),
        .pass       (pass),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Scoreboard: every done pulse must match the oldest expected session.
    always @(negedge clk) begin
        logic [4:0] e;
        if (done !== '0) begin
            if (sb.size() == 0) begin
                check("sb_extra_done", 32'(done), 32'h0);
            end else begin
                e = sb.pop_front();
                check("sb_done", 32'(done), 32'(e[4:1]));
                check("sb_pass", 32'(pass), 32'(e[0]));
            end
        end
    end

    // d > 0: finish d cycles after the start cycle; d == 0: let it time out.
    task automatic session(input logic [3:0] r, input logic [3:0] eg,
                           input logic [15:0] sig, input logic [15:0] gold,
                           input int d, input logic ep, input bit keep);
        int w;
        bit got;
        req    = r;
        golden = gold;
        sb.push_back({eg, ep});
        w   = 0;
        got = 0;
        while (!got && w < 8) begin
            tick();
            w++;
            if (bist_start) got = 1;
        end
        last_wait = w;
        check("start_seen", 32'(got), 32'h1);
        check("grant", 32'(grant), 32'(eg));
        tick();
        check("start_pulse", 32'(bist_start), 32'h0);
        if (d > 0) begin
            repeat (d - 1) tick();
            bist_finish = 1'b1;
            signature   = sig;
            tick();
            bist_finish = 1'b0;
        end else begin
            repeat (NT - 1) tick();
            check("to_early", 32'(done), 32'h0);
            tick();
        end
        check("done_t", 32'(done), 32'(eg));
        check("pass_t", 32'(pass), 32'(ep));
        if (!keep) req = '0;
        tick();
        check("done_1cyc", 32'(done), 32'h0);
        check("pass_0", 32'(pass), 32'h0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_pass"}, 32'(pass), 32'h0);
        check({tag, "_start"}, 32'(bist_start), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_toerr"}, 32'(timeout_err), 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset       = 1'b1;
        req         = '0;
        bist_finish = 1'b0;
        signature   = '0;
        golden      = '0;
        tick();
        tick();
        check_zero("rst");
        reset = 1'b0;
        tick();

        // single passing session, 650 cycles
        session(4'b0001, 4'b0001, 16'hA5A5, 16'hA5A5, 650, 1'b1, 1'b0);
        check("latency", 32'(last_wait), 32'h1);
        check("idle_busy", 32'(busy), 32'h0);

        // signature mismatch
        session(4'b0001, 4'b0001, 16'hA5A4, 16'hA5A5, 650, 1'b0, 1'b0);
        check("fail_toerr", 32'(timeout_err), 32'h0);

        // stray finish while idle
        bist_finish = 1'b1;
        signature   = 16'h1234;
        tick();
        bist_finish = 1'b0;
        check("stray_busy", 32'(busy), 32'h0);
        tick();
        check("stray_done", 32'(done), 32'h0);
        check("stray_busy2", 32'(busy), 32'h0);

        // round robin with all requesters held
        do_reset();
        session(4'b1111, 4'b0001, 16'h00FF, 16'h00FF, 5, 1'b1, 1'b1);
        session(4'b1111, 4'b0010, 16'h00FF, 16'h00FF, 5, 1'b1, 1'b1);
        session(4'b1111, 4'b0100, 16'h00FF, 16'h00FF, 5, 1'b1, 1'b1);
        session(4'b1111, 4'b1000, 16'h00FF, 16'h00FF, 5, 1'b1, 1'b1);
        session(4'b1111, 4'b0001, 16'h00FF, 16'h00FF, 5, 1'b1, 1'b0);

        // finish on the last allowed wait cycle wins over timeout
        session(4'b0010, 4'b0010, 16'h5A5A, 16'h5A5A, NT, 1'b1, 1'b0);
        check("coinc_toerr", 32'(timeout_err), 32'h0);

        // real timeout, then the flag stays sticky
        session(4'b1000, 4'b1000, 16'h0, 16'h5A5A, 0, 1'b0, 1'b0);
        check("to_err_set", 32'(timeout_err), 32'h1);
        session(4'b0001, 4'b0001, 16'h7777, 16'h7777, 3, 1'b1, 1'b0);
        check("to_err_sticky", 32'(timeout_err), 32'h1);

        // reset in the middle of WAIT aborts without done
        req    = 4'b0100;
        golden = 16'hBEEF;
        begin
            int w;
            w = 0;
            while (!bist_start && w < 8) begin
                tick();
                w++;
            end
            check("mid_start", 32'(bist_start), 32'h1);
        end
        repeat (5) tick();
        check("mid_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        check_zero("mid_rst");
        req = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        session(4'b0100, 4'b0100, 16'hBEEF, 16'hBEEF, 20, 1'b1, 1'b0);
        check("post_toerr", 32'(timeout_err), 32'h0);

        repeat (3) tick();
        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
